// File: rtl/rtc_read_seq_pkg.sv
// Shared definitions for the RTC read sequencer: FSM encoding, RTC register
// addresses and sweep index limits.
package rtc_read_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR_WR   = 3'd1,
    ADDR_HOLD = 3'd2,
    DATA_RD   = 3'd3,
    LATCH     = 3'd4,
    RELEASE   = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam logic [7:0] ADDR_SEG      = 8'h21;
  localparam logic [7:0] ADDR_MIN      = 8'h22;
  localparam logic [7:0] ADDR_HORA     = 8'h23;
  localparam logic [7:0] ADDR_DIA      = 8'h24;
  localparam logic [7:0] ADDR_MES      = 8'h25;
  localparam logic [7:0] ADDR_YEAR     = 8'h26;
  localparam logic [7:0] ADDR_SEG_TIM  = 8'h41;
  localparam logic [7:0] ADDR_MIN_TIM  = 8'h42;
  localparam logic [7:0] ADDR_HORA_TIM = 8'h43;

  localparam logic [3:0] IDX_FIRST      = 4'd1;
  localparam logic [3:0] IDX_LAST_DATE  = 4'd6;
  localparam logic [3:0] IDX_LAST_TIMER = 4'd9;

  // Destination index to RTC register address; out-of-range indices map to 0x00.
  function automatic logic [7:0] idx_to_addr(input logic [3:0] idx);
    logic [7:0] addr;
    case (idx)
      4'd1:    addr = ADDR_SEG;
      4'd2:    addr = ADDR_MIN;
      4'd3:    addr = ADDR_HORA;
      4'd4:    addr = ADDR_DIA;
      4'd5:    addr = ADDR_MES;
      4'd6:    addr = ADDR_YEAR;
      4'd7:    addr = ADDR_SEG_TIM;
      4'd8:    addr = ADDR_MIN_TIM;
      4'd9:    addr = ADDR_HORA_TIM;
      default: addr = 8'h00;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/rtc_read_seq_phase_timer.sv
// Bus phase timer: loads a count, counts down, and pulses o_expire for one
// cycle when the loaded phase has run out.
module rtc_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic       o_expire
);

  logic [7:0] r_count;
  logic       r_active;

  // A load of N gives an expire pulse in the (N+1)-th cycle after the load edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= 8'd0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_count  <= i_load_val;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == 8'd0) begin
        r_active <= 1'b0;
      end else begin
        r_count <= r_count - 8'd1;
      end
    end
  end

  assign o_expire = r_active && (r_count == 8'd0);

endmodule

// File: rtl/rtc_read_seq.sv
// RTC read sequencer: sweeps the RTC date registers (and the timer registers
// when RTC_TIMER_READ_EN is defined), strobing each value into a register bank.
module rtc_read_seq
  import rtc_read_seq_pkg::*;
#(
  parameter int T_PHASE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad,
  output logic [7:0] addr_out,
  output logic       addr_oe,
  output logic       LL_signal,
  output logic [3:0] reg_select
);

`ifdef RTC_TIMER_READ_EN
  localparam logic [3:0] IDX_LAST = IDX_LAST_TIMER;
`else
  localparam logic [3:0] IDX_LAST = IDX_LAST_DATE;
`endif

  localparam logic [7:0] PHASE_LOAD = 8'(T_PHASE - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_index;
  logic       w_expire;
  logic       w_load;

  // Every state change reloads the timer, so each timed phase gets a full T_PHASE.
  assign w_load = (w_next != r_state);

  rtc_phase_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (PHASE_LOAD),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_index <= 4'd0;
    end else begin
      r_state <= w_next;
      if (((r_state == IDLE) || (r_state == DONE)) && start) begin
        r_index <= IDX_FIRST;
      end else if ((r_state == RELEASE) && w_expire && (r_index != IDX_LAST)) begin
        r_index <= r_index + 4'd1;
      end
    end
  end

  // DONE goes straight to ADDR_WR when start is still high so held-start sweeps abut.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (start)    w_next = ADDR_WR;
      ADDR_WR:   if (w_expire) w_next = ADDR_HOLD;
      ADDR_HOLD: if (w_expire) w_next = DATA_RD;
      DATA_RD:   if (w_expire) w_next = LATCH;
      LATCH:                   w_next = RELEASE;
      RELEASE: begin
        if (w_expire) begin
          w_next = (r_index == IDX_LAST) ? DONE : ADDR_WR;
        end
      end
      DONE:      w_next = start ? ADDR_WR : IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != IDLE);
    done       = 1'b0;
    cs_n       = 1'b1;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    ad         = 1'b0;
    addr_out   = 8'h00;
    addr_oe    = 1'b0;
    LL_signal  = 1'b0;
    reg_select = 4'd0;
    case (r_state)
      ADDR_WR: begin
        cs_n     = 1'b0;
        wr_n     = 1'b0;
        addr_oe  = 1'b1;
        addr_out = idx_to_addr(r_index);
      end
      ADDR_HOLD: begin
        cs_n     = 1'b0;
        addr_oe  = 1'b1;
        addr_out = idx_to_addr(r_index);
      end
      DATA_RD: begin
        cs_n = 1'b0;
        rd_n = 1'b0;
        ad   = 1'b1;
      end
      LATCH: begin
        cs_n       = 1'b0;
        rd_n       = 1'b0;
        ad         = 1'b1;
        LL_signal  = 1'b1;
        reg_select = r_index;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/rtc_read_seq.md
RTC_READ_SEQ -- requirements
Module: rtc_read_seq

Interface
REQ-001 SHALL have parameter T_PHASE, default 8, bus phase length in clk cycles (legal 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request one full read sweep of the RTC.
REQ-005 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-006 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-007 SHALL have ports cs_n, rd_n, wr_n  output  1 each  RTC bus strobes, active-low.
REQ-008 SHALL have port ad  output  1  RTC A/D select: 0 = address phase, 1 = data phase.
REQ-009 SHALL have port addr_out  output  8  RTC register address driven in the address phase.
REQ-010 SHALL have port addr_oe  output  1  enables the external tristate driver of addr_out onto the shared 8-bit RTC bus.
REQ-011 SHALL have port LL_signal  output  1  one-cycle capture strobe for the downstream RTC register bank.
REQ-012 SHALL have port reg_select  output  4  destination index, 1..9, valid whenever LL_signal = 1.

Function
REQ-013 SHALL implement FSM states IDLE, ADDR_WR, ADDR_HOLD, DATA_RD, LATCH, RELEASE, DONE.
REQ-014 In IDLE: start=1 SHALL load index 1 and go to ADDR_WR on the next edge; start=0 SHALL remain in IDLE.
REQ-015 ADDR_WR (T_PHASE cycles): cs_n=0, wr_n=0, rd_n=1, ad=0, addr_oe=1, addr_out = address of current index.
REQ-016 ADDR_HOLD (T_PHASE cycles): as ADDR_WR but with wr_n=1.
REQ-017 DATA_RD (T_PHASE cycles): cs_n=0, rd_n=0, ad=1, addr_oe=0.
REQ-018 LATCH (exactly 1 cycle): same bus levels as DATA_RD, with LL_signal=1 and reg_select = current index.
REQ-019 RELEASE (T_PHASE cycles): cs_n=1, rd_n=1, wr_n=1, addr_oe=0; on exit, if index = last, go to DONE, else increment index and go to ADDR_WR.
REQ-020 DONE (1 cycle): done=1, then go to IDLE.
REQ-021 Index-to-address map SHALL be: 1→0x21 seg, 2→0x22 min, 3→0x23 hora, 4→0x24 dia, 5→0x25 mes, 6→0x26 year, 7→0x41 seg_tim, 8→0x42 min_tim, 9→0x43 hora_tim.
REQ-022 One register SHALL take 4*T_PHASE+1 cycles; done SHALL rise exactly 1 + N*(4*T_PHASE+1) cycles after the edge sampling start, where N = number of registers read.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 start asserted while busy=1 SHALL be ignored, not queued.
REQ-025 start held high continuously SHALL begin a new sweep on the cycle after DONE.
REQ-026 The phase counter SHALL be 8 bits wide and reload on every state entry.
REQ-027 In IDLE and DONE: cs_n=rd_n=wr_n=1, ad=0, addr_oe=0, addr_out=0x00, LL_signal=0, reg_select=0.
REQ-028 rd_n and wr_n SHALL never be low in the same cycle; addr_oe SHALL never be 1 while rd_n=0.

Reset
REQ-029 On reset=1 at a rising edge, the block SHALL enter IDLE with all outputs at the REQ-027 values, busy=0, done=0, and index=0.
REQ-030 Reset mid-sweep SHALL abort the sweep: the bus is released on the next edge, and no LL_signal or done is emitted for the aborted sweep.

Configuration
REQ-031 With macro RTC_TIMER_READ_EN defined, a sweep SHALL read indices 1..9 (N=9).
REQ-032 Without RTC_TIMER_READ_EN, a sweep SHALL read indices 1..6 only (N=6), and addresses 0x41..0x43 SHALL never appear on addr_out.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding, the nine RTC address constants, and the index constants IDX_FIRST, IDX_LAST_DATE=6 and IDX_LAST_TIMER=9.
REQ-034 The phase timer SHALL be a sub-module, rtc_phase_timer (load, count down, expire pulse); all other logic stays in rtc_read_seq.

Verification
REQ-035 Scenario: T_PHASE=8, RTC_TIMER_READ_EN defined, 1-cycle start pulse -> done high 298 cycles later; nine LL_signal pulses with reg_select 1..9 in order; addr_out sequence 0x21..0x26, 0x41..0x43.
REQ-036 Scenario: macro undefined, T_PHASE=8 -> done high 199 cycles after start; six LL_signal pulses; addr_out never 0x41..0x43.
REQ-037 Scenario: reset asserted in DATA_RD of index 4 -> outputs at REQ-027 values on the next edge; no further LL_signal; a new start gives a full sweep beginning at 0x21.
REQ-038 Scenario: start pulsed during index 3 -> no effect; exactly one done per sweep.
REQ-039 Scenario: T_PHASE=1, start held high -> back-to-back sweeps, 46 cycles apart; protocol checker confirms REQ-028 and one-cycle LL_signal pulses throughout.
REQ-040 Scenario: a bus model returns 0x59 on index 1 read -> 0x59 is stable on the bus during LATCH, and the downstream seg register captures 0x59.
